// File: rtl/video_stream_gen_if.sv
// Video stream bundle: frame control inputs and the vsync/href/gray pixel
// stream with frame status, as seen by the generator (master) and a consumer.
interface video_stream_gen_if;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        frame_vsync;
  logic        frame_href;
  logic [7:0]  img_gray;
  logic        frame_done;
  logic [15:0] frame_cnt;

  modport master (
    input  enable,
    input  pattern_sel,
    output frame_vsync,
    output frame_href,
    output img_gray,
    output frame_done,
    output frame_cnt
  );

  modport slave (
    output enable,
    output pattern_sel,
    input  frame_vsync,
    input  frame_href,
    input  img_gray,
    input  frame_done,
    input  frame_cnt
  );
endinterface

// File: rtl/video_stream_gen.sv
// Synthetic frame-stream source: produces vsync/href/8-bit gray frames with
// configurable active size, horizontal blanking and vertical pre/post/gap
// lines, filled with one of four test patterns latched at each frame start.
// All outputs are registered; they are computed from the next-cycle state and
// counters so that output timing lines up exactly with the state machine.
module video_stream_gen #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [10:0] H_BLANK   = 11'd160,
  parameter logic [10:0] V_PRE     = 11'd2,
  parameter logic [10:0] V_POST    = 11'd2,
  parameter logic [10:0] V_GAP     = 11'd2
) (
  input  logic                      clk,
  input  logic                      rst,
  video_stream_gen_if.master        vif
);

  // Total clocks per line; one extra bit so the sum of two 11-bit values fits.
  localparam logic [11:0] HT     = {1'b0, IMG_HDISP} + {1'b0, H_BLANK};
  localparam logic [11:0] H_LAST = HT - 12'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACTIVE,
    S_POST,
    S_GAP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_h_cnt;
  logic [11:0] w_h_nxt;
  logic [10:0] r_v_cnt;
  logic [10:0] w_v_nxt;
  logic [10:0] w_v_len;
  logic [1:0]  r_pat;
  logic [1:0]  w_pat_nxt;
  logic [15:0] r_frame_cnt;
  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_gray;
  logic        r_done;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_enter_gap;
  logic        w_vsync_nxt;
  logic        w_href_nxt;
  logic [7:0]  w_gray_nxt;

  // Pixel value for pattern sel at coordinate (x, y); fc is the completed
  // frame count so pattern 3 scrolls from frame to frame.
  function automatic logic [7:0] f_pixel(input logic [1:0] sel,
                                         input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic [7:0] fc);
    logic [7:0] pix;
    case (sel)
      2'd0:    pix = x;
      2'd1:    pix = y;
      2'd2:    pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      default: pix = x + y + fc;
    endcase
    return pix;
  endfunction

  // Number of lines spent in the current vertical state.
  always_comb begin
    w_v_len = 11'd1;
    case (r_state)
      S_PRE:    w_v_len = V_PRE;
      S_ACTIVE: w_v_len = IMG_VDISP;
      S_POST:   w_v_len = V_POST;
      S_GAP:    w_v_len = V_GAP;
      default:  w_v_len = 11'd1;
    endcase
  end

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == (w_v_len - 11'd1));

  // Next state, counters and pattern latch; enable is only looked at in IDLE
  // and on the last clock of GAP, so a started frame always runs to the end.
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    w_pat_nxt   = r_pat;
    if (r_state == S_IDLE) begin
      w_h_nxt = 12'd0;
      w_v_nxt = 11'd0;
      if (vif.enable) begin
        w_state_nxt = S_PRE;
        w_pat_nxt   = vif.pattern_sel;
      end
    end else if (!w_h_last) begin
      w_h_nxt = r_h_cnt + 12'd1;
    end else begin
      w_h_nxt = 12'd0;
      if (!w_v_last) begin
        w_v_nxt = r_v_cnt + 11'd1;
      end else begin
        w_v_nxt = 11'd0;
        case (r_state)
          S_PRE:    w_state_nxt = S_ACTIVE;
          S_ACTIVE: w_state_nxt = S_POST;
          S_POST:   w_state_nxt = S_GAP;
          S_GAP: begin
            if (vif.enable) begin
              w_state_nxt = S_PRE;
              w_pat_nxt   = vif.pattern_sel;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
          default:  w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Output values for the coming cycle, derived from the next state/counters.
  always_comb begin
    w_enter_gap = (w_state_nxt == S_GAP) && (r_state != S_GAP);
    w_vsync_nxt = (w_state_nxt == S_PRE) || (w_state_nxt == S_ACTIVE) ||
                  (w_state_nxt == S_POST);
    w_href_nxt  = (w_state_nxt == S_ACTIVE) && (w_h_nxt < {1'b0, IMG_HDISP});
    w_gray_nxt  = 8'h00;
    if (w_href_nxt) begin
      w_gray_nxt = f_pixel(w_pat_nxt, w_h_nxt[7:0], w_v_nxt[7:0], r_frame_cnt[7:0]);
    end
  end

  // State, counters, pattern latch and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_h_cnt     <= 12'd0;
      r_v_cnt     <= 11'd0;
      r_pat       <= 2'd0;
      r_frame_cnt <= 16'd0;
      r_vsync     <= 1'b0;
      r_href      <= 1'b0;
      r_gray      <= 8'h00;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_h_cnt     <= w_h_nxt;
      r_v_cnt     <= w_v_nxt;
      r_pat       <= w_pat_nxt;
      r_frame_cnt <= r_frame_cnt + {15'd0, w_enter_gap};
      r_vsync     <= w_vsync_nxt;
      r_href      <= w_href_nxt;
      r_gray      <= w_gray_nxt;
      r_done      <= w_enter_gap;
    end
  end

  assign vif.frame_vsync = r_vsync;
  assign vif.frame_href  = r_href;
  assign vif.img_gray    = r_gray;
  assign vif.frame_done  = r_done;
  assign vif.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: a frame-position reference model pushes the
// expected stream values each clock, a monitor pops and compares them, and a
// second monitor checks frame geometry (run lengths, offsets, done timing).
module tb_video_stream_gen;
  localparam int HD    = 8;
  localparam int VD    = 4;
  localparam int HB    = 4;
  localparam int VPRE  = 1;
  localparam int VPOST = 1;
  localparam int VGAP  = 2;
  localparam int HT    = HD + HB;
  localparam int FP    = (VPRE + VD + VPOST + VGAP) * HT;
  localparam int VSL   = (VPRE + VD + VPOST) * HT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  video_stream_gen_if vif();
  video_stream_gen_if vif16();

  video_stream_gen #(
    .IMG_HDISP(11'd8), .IMG_VDISP(11'd4), .H_BLANK(11'd4),
    .V_PRE(11'd1), .V_POST(11'd1), .V_GAP(11'd2)
  ) dut (
    .clk(clk), .rst(rst), .vif(vif)
  );

  video_stream_gen #(
    .IMG_HDISP(11'd16), .IMG_VDISP(11'd4), .H_BLANK(11'd4),
    .V_PRE(11'd1), .V_POST(11'd1), .V_GAP(11'd2)
  ) dut16 (
    .clk(clk), .rst(rst), .vif(vif16)
  );

  typedef struct packed {
    logic        vs;
    logic        hr;
    logic [7:0]  g;
    logic        dn;
    logic [15:0] c;
  } exp_t;

  exp_t exp_q[$];

  // reference model state: position within the current frame
  bit          m_act = 1'b0;
  int          m_t = 0;
  logic [1:0]  m_pat = 2'd0;
  logic [15:0] m_fcnt = 16'd0;
  int          preload_seq = 0;
  int          preload_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  function automatic logic [7:0] ref_pix(input logic [1:0] sel, input int x, input int y,
                                         input logic [15:0] fc);
    case (sel)
      2'd0:    return 8'(x);
      2'd1:    return 8'(y);
      2'd2:    return ((((x / 8) + (y / 8)) % 2) == 1) ? 8'hFF : 8'h00;
      default: return 8'(x + y + int'(fc[7:0]));
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int line, x;
    e = '0;
    e.c = m_fcnt;
    if (m_act) begin
      line = m_t / HT;
      x    = m_t % HT;
      e.vs = (m_t < VSL);
      e.dn = (m_t == VSL);
      if (line >= VPRE && line < VPRE + VD && x < HD) begin
        e.hr = 1'b1;
        e.g  = ref_pix(m_pat, x, line - VPRE, m_fcnt);
      end
    end
    return e;
  endfunction

  // reference model: advance one clock and queue the expected outputs
  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0;
      m_t = 0;
      m_fcnt = 16'd0;
      m_pat = 2'd0;
      preload_seen = preload_seq;
    end else begin
      if (preload_seen != preload_seq) begin
        m_fcnt = 16'hFFFF;
        preload_seen = preload_seq;
      end
      if (!m_act) begin
        if (vif.enable) begin
          m_act = 1'b1;
          m_t = 0;
          m_pat = vif.pattern_sel;
        end
      end else begin
        m_t++;
        if (m_t == FP) begin
          m_t = 0;
          if (vif.enable) m_pat = vif.pattern_sel;
          else m_act = 1'b0;
        end else if (m_t == VSL) begin
          m_fcnt = m_fcnt + 16'd1;
        end
      end
    end
    exp_q.push_back(model_out());
  end

  // scoreboard monitor: compare every presented cycle against the model
  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rst) e = '0;
      a.vs = vif.frame_vsync;
      a.hr = vif.frame_href;
      a.g  = vif.img_gray;
      a.dn = vif.frame_done;
      a.c  = vif.frame_cnt;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL stream @%0t: got vs=%b href=%b gray=%02h done=%b cnt=%04h, expected vs=%b href=%b gray=%02h done=%b cnt=%04h",
                 $time, a.vs, a.hr, a.g, a.dn, a.c, e.vs, e.hr, e.g, e.dn, e.c);
      end
    end
  end

  // geometry monitor: href run lengths, first-run offset, done at vsync fall
  bit p_vs = 1'b0, p_hr = 1'b0, first = 1'b1;
  int vs_len = 0, hr_len = 0, runs = 0, off = 0;
  always @(negedge clk) begin
    if (rst) begin
      p_vs = 1'b0; p_hr = 1'b0; first = 1'b1;
      vs_len = 0; hr_len = 0; runs = 0; off = 0;
    end else begin
      if (vif.frame_vsync && !p_vs) begin
        vs_len = 1; runs = 0; off = 0; first = 1'b1;
      end else begin
        if (vif.frame_vsync) vs_len++;
        off++;
      end
      if (vif.frame_href) begin
        hr_len = p_hr ? hr_len + 1 : 1;
        if (!p_hr && first) begin
          chk("first href offset", off, VPRE * HT);
          first = 1'b0;
        end
      end else if (p_hr) begin
        chk("href run length", hr_len, HD);
        runs++;
      end
      if (!vif.frame_vsync && p_vs) begin
        chk("vsync high length", vs_len, VSL);
        chk("href runs per frame", runs, VD);
        chk("done at vsync fall", {31'd0, vif.frame_done}, 1);
      end else if (vif.frame_done) begin
        chk("done away from vsync fall", {31'd0, vif.frame_done}, 0);
      end
      p_vs = vif.frame_vsync;
      p_hr = vif.frame_href;
    end
  end

  // wide instance: first active line of pattern 2 is 00 x8 then FF x8
  initial begin : wide_check
    bit found;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (!rst && vif16.frame_href) found = 1'b1;
    end
    chk("wide first href seen", {31'd0, found}, 1);
    if (found) begin
      for (int x = 0; x < 16; x++) begin
        if (x > 0) @(negedge clk);
        chk("wide p2 href", {31'd0, vif16.frame_href}, 1);
        chk("wide p2 pixel", {24'd0, vif16.img_gray}, {24'd0, ref_pix(2'd2, x, 0, 16'd0)});
      end
      @(negedge clk);
      chk("wide p2 run end", {31'd0, vif16.frame_href}, 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (vif.frame_done) seen = 1'b1;
    end
    if (!seen) chk(name, 0, 1);
  endtask

  task automatic wait_href_rise(input int budget, input string name);
    bit seen, prev;
    seen = 1'b0;
    prev = vif.frame_href;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (vif.frame_href && !prev) seen = 1'b1;
      prev = vif.frame_href;
    end
    if (!seen) chk(name, 0, 1);
  endtask

  logic [1:0] sel_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};

  initial begin
    vif.enable = 1'b0;
    vif.pattern_sel = 2'd0;
    vif16.enable = 1'b0;
    vif16.pattern_sel = 2'd2;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    vif16.enable = 1'b1;

    // idle with enable low
    cycles(50);
    chk("idle outputs", {20'd0, vif.frame_vsync, vif.frame_href, vif.img_gray, vif.frame_done},
        32'd0);
    chk("idle frame_cnt", {16'd0, vif.frame_cnt}, 32'd0);

    // back-to-back pattern 0 frames
    vif.enable = 1'b1;
    wait_done(200, "frame 1 done timeout");
    wait_done(200, "frame 2 done timeout");
    chk("frame_cnt after 2", {16'd0, vif.frame_cnt}, 32'd2);

    // mid-frame pattern changes take effect on the following frame
    for (int i = 0; i < 5; i++) begin
      cycles(30);
      vif.pattern_sel = sel_seq[i];
      wait_done(200, "pattern frame done timeout");
    end

    // preload frame_cnt to FFFF during GAP; next frame uses it, then wraps
    #1;
    force dut.r_frame_cnt = 16'hFFFF;
    preload_seq++;
    @(negedge clk);
    #1;
    release dut.r_frame_cnt;
    wait_done(200, "wrap frame done timeout");
    chk("frame_cnt wrap", {16'd0, vif.frame_cnt}, 32'd0);

    // drop enable during ACTIVE: frame completes, then stays idle
    wait_href_rise(200, "href before drop timeout");
    cycles(3);
    vif.enable = 1'b0;
    wait_done(200, "dropped frame done timeout");
    cycles(150);
    chk("idle after drop", {30'd0, vif.frame_vsync, vif.frame_href}, 32'd0);

    // reset during second active line
    vif.enable = 1'b1;
    wait_href_rise(200, "line0 href timeout");
    wait_href_rise(200, "line1 href timeout");
    cycles(3);
    rst = 1'b1;
    #1;
    chk("async reset outputs",
        {5'd0, vif.frame_vsync, vif.frame_href, vif.img_gray, vif.frame_done, vif.frame_cnt},
        32'd0);
    cycles(2);
    rst = 1'b0;
    wait_done(200, "post-reset done timeout");
    chk("frame_cnt after reset", {16'd0, vif.frame_cnt}, 32'd1);

    // randomized enable and pattern select
    for (int i = 0; i < 40; i++) begin
      vif.enable = ($urandom_range(0, 3) != 0);
      vif.pattern_sel = 2'($urandom_range(0, 3));
      cycles($urandom_range(1, 150));
    end
    vif.enable = 1'b0;
    cycles(200);
    chk("final idle", {30'd0, vif.frame_vsync, vif.frame_href}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_stream_gen.md
# video_stream_gen

Frame-stream source for the video processing pipeline. It drives the same vsync/href/8-bit gray pixel stream that the 3x3 matrix generator and the downstream filters consume. Configurable active size, horizontal blanking and vertical pre/post/gap lines give full control of the frame geometry. A selectable synthetic pattern lets benches and bring-up run without a camera.

## Interface
- IMG_HDISP, 11'd640, active pixels per line (min 2)
- IMG_VDISP, 11'd480, active lines per frame (min 2)
- H_BLANK, 11'd160, blank clocks after each line's active pixels (min 1)
- V_PRE, 11'd2, lines with vsync high and href low before active lines (min 1)
- V_POST, 11'd2, lines with vsync high and href low after active lines (min 1)
- V_GAP, 11'd2, lines with vsync low between frames (min 1)

Ports:
- clk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; start frames, or keep streaming frames
- pattern_sel  in  2  pattern select, sampled at each frame start
- frame_vsync  out  1  frame valid; high through PRE, ACTIVE and POST
- frame_href  out  1  line valid; high only on active pixels
- img_gray  out  8  pixel value; 0 whenever frame_href is low
- frame_done  out  1  one-cycle pulse at end of frame
- frame_cnt  out  16  completed-frame count, wraps at 16'hFFFF to 0

## Operation
- State machine: IDLE, PRE, ACTIVE, POST, GAP.
- Horizontal counter h_cnt counts 0..HT-1, where HT = IMG_HDISP + H_BLANK. Line counter v_cnt counts lines within the current state.
- IDLE: all outputs low, counters 0. If enable = 1, go to PRE and latch pattern_sel into pat_r.
- PRE: lasts V_PRE lines, then ACTIVE.
- ACTIVE: lasts IMG_VDISP lines, then POST. Within a line, frame_href = 1 for h_cnt 0..IMG_HDISP-1. Pixel coordinates are x = h_cnt and y = active line index 0..IMG_VDISP-1.
- POST: lasts V_POST lines, then GAP.
- GAP: lasts V_GAP lines. At the end of the last line:
  - enable = 1: go straight to PRE and re-latch pattern_sel; there is no IDLE cycle.
  - enable = 0: go to IDLE.
- enable is checked only in IDLE and at the end of GAP. Deasserting it mid-frame lets the current frame complete.
- Patterns, applied when href = 1 (arithmetic truncated to 8 bits):
  - 0: x[7:0]
  - 1: y[7:0]
  - 2: 8'hFF if x[3]^y[3], else 8'h00
  - 3: x + y + frame_cnt[7:0]
- Entering GAP:
  - frame_done pulses for the first GAP cycle.
  - frame_cnt increments in that same cycle.
- pattern_sel changes mid-frame have no effect until the next frame start.

## Timing
- Reset (async assert, applied immediately): state IDLE, all counters 0. Every output is 0: frame_vsync, frame_href, img_gray, frame_done, frame_cnt.
- Reset asserted mid-frame truncates the frame immediately. frame_done does not pulse and frame_cnt stays 0.
- Frame start: enable sampled high in IDLE at edge N makes frame_vsync = 1 from cycle N+1.
- All outputs are registered. frame_href and img_gray change together in the same cycle.
- First active pixel appears V_PRE × HT cycles after vsync rises.
- Frame period is (V_PRE + IMG_VDISP + V_POST + V_GAP) × HT cycles. vsync is high for (V_PRE + IMG_VDISP + V_POST) × HT of them.
- href runs of exactly IMG_HDISP cycles are separated by H_BLANK low cycles. There are exactly IMG_VDISP runs per frame.
- frame_vsync falls in the same cycle frame_done pulses.

## Test plan
All scenarios use IMG_HDISP = 8, IMG_VDISP = 4, H_BLANK = 4, V_PRE = 1, V_POST = 1, V_GAP = 2. This gives HT = 12 and a 96-cycle frame.
- Reset / idle: rst pulse, enable = 0 for 50 cycles -> all outputs 0, frame_cnt = 0.
- Geometry, pattern 0:
  - enable held high -> vsync high 72 cycles, then low 24 cycles.
  - Per frame: 4 href runs of 8 cycles, first run starting 12 cycles after vsync rises.
  - img_gray = 0..7 on each run; period 96 with no idle gap.
- Patterns 1 and 2:
  - Pattern 1: line k of a frame gives img_gray = k for all 8 pixels.
  - Pattern 2: line 0 gives 00 ×8.
  - Pattern 2 with IMG_HDISP = 16: line 0 gives 00 ×8 then FF ×8.
- Pattern 3 and counter:
  - Second frame, first pixel = 1 (frame_cnt = 1).
  - frame_done pulses once per frame, coincident with vsync falling.
  - frame_cnt preloaded by force to FFFF wraps to 0.
- Enable drop / select change:
  - Drop enable during ACTIVE -> frame completes, then IDLE, outputs stay low.
  - pattern_sel changed mid-frame -> takes effect only on the next frame.
- Reset mid-frame: assert rst during the second active line -> outputs 0 in the same cycle. After release with enable = 1, a full frame restarts from PRE with frame_cnt = 0.
